// File: rtl/wb_resolve.sv
// Writeback and branch-resolve stage: registers results and register-file write lanes,
// resolves branches against the fetch prediction, and issues redirect/flush, squash, halt and statistics.
module wb_resolve #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PREDICT = 1,
  parameter int unsigned SQUASH  = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [63:0]      ir_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] pc_fall_i,
  input  logic [2:0]       ccr_i,
  input  logic [1:0]       reg_write_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic [WIDTH-1:0] result_hi_i,
  input  logic             pred_taken_i,
  input  logic             stall_i,
  output logic             stall_o,
  input  logic             halt_i,
  output logic             halt_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [1:0]       reg_write_o,
  output logic [3:0]       reg_write_addr,
  output logic [3:0]       reg_write_hi_addr,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_set,
  output logic             flush_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);

  localparam int unsigned SQ_W     = 3;
  localparam logic [3:0]  T_BRANCH = 4'hc;
  localparam logic [3:0]  T_JUMP   = 4'hd;

  logic [3:0] ir_type, ir_op, ra;
  assign ir_type = ir_i[31:28];
  assign ir_op   = ir_i[27:24];
  assign ra      = ir_i[23:20];

  logic unused_ir;
  assign unused_ir = ^{ir_i[63:32], ir_i[19:0]};

  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d, pc_q, pc_d;
  logic [1:0]       reg_write_q, reg_write_d;
  logic [3:0]       wa_q, wa_d, wah_q, wah_d;
  logic             pc_set_q, pc_set_d, halt_q, halt_d;
  logic [SQ_W-1:0]  squash_q, squash_d;
  logic [CNT_W-1:0] br_q, br_d, mp_q, mp_d;
  logic             cond, is_cf, counted, taken, redirect;

  // Branch resolution, then next-state selection: stall holds, squash/halt suppress.
  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    pc_d        = pc_q;
    reg_write_d = reg_write_q;
    wa_d        = wa_q;
    wah_d       = wah_q;
    pc_set_d    = pc_set_q;
    halt_d      = halt_q;
    squash_d    = squash_q;
    br_d        = br_q;
    mp_d        = mp_q;
    cond        = 1'b0;

    case (ir_op)
      4'h0:    cond = 1'b1;
      4'h1:    cond = ccr_i[0];
      4'h2:    cond = ~ccr_i[0];
      4'h3:    cond = ~(ccr_i[2] | ccr_i[0]);
      4'h4:    cond = ~(ccr_i[1] | ccr_i[0]);
      4'h5:    cond = ~ccr_i[1];
      4'h6:    cond = ccr_i[1] | ccr_i[0];
      4'h7:    cond = ccr_i[1];
      4'h8:    cond = ~ccr_i[2];
      4'h9:    cond = ccr_i[2];
      4'ha:    cond = ccr_i[2] | ccr_i[0];
      default: cond = 1'b0;
    endcase

    is_cf   = (ir_type == T_BRANCH) || (ir_type == T_JUMP);
    counted = (ir_type == T_JUMP) || ((ir_type == T_BRANCH) && (ir_op <= 4'ha));
    taken   = (ir_type == T_JUMP) || ((ir_type == T_BRANCH) && cond);
    if (PREDICT != 0) redirect = is_cf && (taken != pred_taken_i);
    else              redirect = taken;

    if (!stall_i) begin
      result_d    = result_i;
      result_hi_d = result_hi_i;
      wa_d        = ra;
      wah_d       = ra + 4'd1;
      pc_d        = pc_i;
      pc_set_d    = 1'b0;
      reg_write_d = 2'b00;
      if (squash_q != '0) begin
        squash_d = squash_q - SQ_W'(1);
      end else if (!halt_q) begin
        reg_write_d = reg_write_i;
        if (halt_i) halt_d = 1'b1;
        if (redirect) begin
          pc_set_d = 1'b1;
          pc_d     = taken ? result_i : pc_fall_i;
          squash_d = SQ_W'(SQUASH);
          if (mp_q != {CNT_W{1'b1}}) mp_d = mp_q + CNT_W'(1);
        end
        if (counted && (br_q != {CNT_W{1'b1}})) br_d = br_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q    <= '0;
      result_hi_q <= '0;
      pc_q        <= '0;
      reg_write_q <= '0;
      wa_q        <= '0;
      wah_q       <= '0;
      pc_set_q    <= 1'b0;
      halt_q      <= 1'b0;
      squash_q    <= '0;
      br_q        <= '0;
      mp_q        <= '0;
    end else begin
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      pc_q        <= pc_d;
      reg_write_q <= reg_write_d;
      wa_q        <= wa_d;
      wah_q       <= wah_d;
      pc_set_q    <= pc_set_d;
      halt_q      <= halt_d;
      squash_q    <= squash_d;
      br_q        <= br_d;
      mp_q        <= mp_d;
    end
  end

  assign stall_o            = stall_i;
  assign halt_o             = halt_q;
  assign result_o           = result_q;
  assign result_hi_o        = result_hi_q;
  assign reg_write_o        = reg_write_q;
  assign reg_write_addr     = wa_q;
  assign reg_write_hi_addr  = wah_q;
  assign pc_o               = pc_q;
  assign pc_set             = pc_set_q;
  assign flush_o            = pc_set_q;
  assign br_count_o         = br_q;
  assign mispredict_count_o = mp_q;

endmodule

// File: tb/tb_wb_resolve.sv
// Bench for wb_resolve: a predicting (SQUASH=2) and a legacy (SQUASH=1) instance share stimulus
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_wb_resolve;

  localparam logic [3:0] T_BRANCH = 4'hc;
  localparam logic [3:0] T_JUMP   = 4'hd;
  localparam int         CMAX     = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] ir;
  logic [31:0] pc, pc_fall, result, result_hi;
  logic [2:0]  ccr;
  logic [1:0]  rw;
  logic        pred, stall, halt;

  logic        p_stall, p_halt, p_ps, p_fl, l_stall, l_halt, l_ps, l_fl;
  logic [31:0] p_res, p_res_hi, p_pc, l_res, l_res_hi, l_pc;
  logic [1:0]  p_rw, l_rw;
  logic [3:0]  p_wa, p_wah, l_wa, l_wah;
  logic [15:0] p_br, p_mp, l_br, l_mp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_resolve #(.WIDTH(32), .PREDICT(1), .SQUASH(2), .CNT_W(16)) u_p (
    .clk_i(clk), .rst_i(rst), .ir_i(ir), .pc_i(pc), .pc_fall_i(pc_fall), .ccr_i(ccr),
    .reg_write_i(rw), .result_i(result), .result_hi_i(result_hi), .pred_taken_i(pred),
    .stall_i(stall), .stall_o(p_stall), .halt_i(halt), .halt_o(p_halt), .result_o(p_res),
    .result_hi_o(p_res_hi), .reg_write_o(p_rw), .reg_write_addr(p_wa), .reg_write_hi_addr(p_wah),
    .pc_o(p_pc), .pc_set(p_ps), .flush_o(p_fl), .br_count_o(p_br), .mispredict_count_o(p_mp));

  wb_resolve #(.WIDTH(32), .PREDICT(0), .SQUASH(1), .CNT_W(16)) u_l (
    .clk_i(clk), .rst_i(rst), .ir_i(ir), .pc_i(pc), .pc_fall_i(pc_fall), .ccr_i(ccr),
    .reg_write_i(rw), .result_i(result), .result_hi_i(result_hi), .pred_taken_i(pred),
    .stall_i(stall), .stall_o(l_stall), .halt_i(halt), .halt_o(l_halt), .result_o(l_res),
    .result_hi_o(l_res_hi), .reg_write_o(l_rw), .reg_write_addr(l_wa), .reg_write_hi_addr(l_wah),
    .pc_o(l_pc), .pc_set(l_ps), .flush_o(l_fl), .br_count_o(l_br), .mispredict_count_o(l_mp));

  typedef struct {
    logic [31:0] res, res_hi, pc;
    int          rw, wa, wah, sq, br, mp;
    bit          ps, halt;
  } mst_t;

  mst_t m_p, m_l;

  function automatic mst_t mzero();
    mst_t z;
    z.res = 0; z.res_hi = 0; z.pc = 0; z.rw = 0; z.wa = 0; z.wah = 0;
    z.sq = 0; z.br = 0; z.mp = 0; z.ps = 0; z.halt = 0;
    return z;
  endfunction

  // Branch condition from the flag meanings: eq, signed less-than, unsigned less-than.
  function automatic bit cond_ref(int op, logic [2:0] f);
    bit eq, lt, ltu;
    eq = f[0]; lt = f[1]; ltu = f[2];
    case (op)
      0:  return 1;
      1:  return eq;
      2:  return !eq;
      3:  return !ltu && !eq;
      4:  return !lt && !eq;
      5:  return !lt;
      6:  return lt || eq;
      7:  return lt;
      8:  return !ltu;
      9:  return ltu;
      10: return ltu || eq;
      default: return 0;
    endcase
  endfunction

  function automatic mst_t step(mst_t s, bit predict, int sq);
    mst_t n;
    int ty, op, ra;
    bit cf, tk, redir;
    if (stall) return s;
    n = s;
    ty = int'(ir[31:28]); op = int'(ir[27:24]); ra = int'(ir[23:20]);
    n.res = result; n.res_hi = result_hi; n.pc = pc;
    n.wa = ra; n.wah = (ra + 1) % 16;
    n.rw = 0; n.ps = 0;
    if (s.sq > 0) begin
      n.sq = s.sq - 1;
      return n;
    end
    if (s.halt) return n;
    n.rw = int'(rw);
    if (halt) n.halt = 1;
    cf = (ty == int'(T_BRANCH)) || (ty == int'(T_JUMP));
    tk = (ty == int'(T_JUMP)) || (ty == int'(T_BRANCH) && cond_ref(op, ccr));
    redir = predict ? (cf && (tk != pred)) : tk;
    if (redir) begin
      n.ps = 1;
      n.pc = tk ? result : pc_fall;
      n.sq = sq;
      if (n.mp < CMAX) n.mp++;
    end
    if ((ty == int'(T_JUMP)) || (ty == int'(T_BRANCH) && op <= 10))
      if (n.br < CMAX) n.br++;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p <= mzero();
      m_l <= mzero();
    end else begin
      m_p <= step(m_p, 1'b1, 2);
      m_l <= step(m_l, 1'b0, 1);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string t, input mst_t m, input logic st, input logic hl,
                         input logic [31:0] r, input logic [31:0] rh, input logic [1:0] w,
                         input logic [3:0] a, input logic [3:0] ah, input logic [31:0] pcv,
                         input logic ps, input logic fl, input logic [15:0] br, input logic [15:0] mp);
    check({t, ".stall_o"}, 64'(st), 64'(stall));
    check({t, ".halt_o"}, 64'(hl), 64'(m.halt));
    check({t, ".result_o"}, 64'(r), 64'(m.res));
    check({t, ".result_hi_o"}, 64'(rh), 64'(m.res_hi));
    check({t, ".reg_write_o"}, 64'(w), 64'(m.rw));
    check({t, ".reg_write_addr"}, 64'(a), 64'(m.wa));
    check({t, ".reg_write_hi_addr"}, 64'(ah), 64'(m.wah));
    check({t, ".pc_o"}, 64'(pcv), 64'(m.pc));
    check({t, ".pc_set"}, 64'(ps), 64'(m.ps));
    check({t, ".flush_o"}, 64'(fl), 64'(m.ps));
    check({t, ".br_count"}, 64'(br), 64'(m.br));
    check({t, ".mp_count"}, 64'(mp), 64'(m.mp));
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    cmp_all("p", m_p, p_stall, p_halt, p_res, p_res_hi, p_rw, p_wa, p_wah, p_pc, p_ps, p_fl, p_br, p_mp);
    cmp_all("l", m_l, l_stall, l_halt, l_res, l_res_hi, l_rw, l_wa, l_wah, l_pc, l_ps, l_fl, l_br, l_mp);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] ty, input logic [3:0] op, input logic [3:0] ra,
                     input logic [2:0] c, input logic [1:0] w, input logic [31:0] res, input logic pr);
    ir        = {32'h0, ty, op, ra, 20'h0};
    ccr       = c;
    rw        = w;
    result    = res;
    result_hi = res ^ 32'hffff_0000;
    pred      = pr;
    pc        = pc + 32'd4;
    pc_fall   = pc + 32'd4;
    halt      = 1'b0;
    stall     = 1'b0;
  endtask

  initial begin
    logic [3:0] ty;
    rst = 1'b1;
    pc = 32'h0;
    drv(4'h0, 4'h0, 4'h0, 3'b000, 2'b00, 32'h0, 1'b0);
    repeat (2) tick();
    check("reset.halt", 64'(p_halt), 64'h0);
    check("reset.br", 64'(p_br), 64'h0);
    check("reset.pc_set", 64'(p_ps), 64'h0);
    check("reset.rw", 64'(p_rw), 64'h0);
    rst = 1'b0;

    // beq taken, predicted not taken: redirect to target, next instruction squashed
    drv(T_BRANCH, 4'h1, 4'h0, 3'b001, 2'b00, 32'h100, 1'b0);
    tick();
    check("t1.pc_set", 64'(p_ps), 64'h1);
    check("t1.flush", 64'(p_fl), 64'h1);
    check("t1.pc_o", 64'(p_pc), 64'h100);
    check("t1.mp", 64'(p_mp), 64'h1);
    drv(4'h0, 4'h0, 4'h3, 3'b000, 2'b01, 32'h55, 1'b0);
    tick();
    check("t1.squashed_rw", 64'(p_rw), 64'h0);
    drv(4'h0, 4'h0, 4'h0, 3'b000, 2'b00, 32'h0, 1'b0);
    tick();

    // bne not taken but predicted taken: redirect to fall-through
    drv(T_BRANCH, 4'h2, 4'h0, 3'b001, 2'b00, 32'h300, 1'b1);
    pc_fall = 32'h204;
    tick();
    check("t2.pc_set", 64'(p_ps), 64'h1);
    check("t2.pc_o", 64'(p_pc), 64'h204);
    drv(4'h0, 4'h0, 4'h0, 3'b000, 2'b00, 32'h0, 1'b0);
    repeat (2) tick();
    drv(T_BRANCH, 4'h4, 4'h0, 3'b000, 2'b00, 32'h500, 1'b1);
    tick();
    check("t2.bgt_pc_set", 64'(p_ps), 64'h0);
    check("t2.br", 64'(p_br), 64'h3);
    check("t2.mp", 64'(p_mp), 64'h2);

    // legacy instance: jump always redirects; ra=15 wraps high address
    drv(4'h0, 4'h0, 4'h0, 3'b000, 2'b00, 32'h0, 1'b0);
    tick();
    drv(T_JUMP, 4'h0, 4'h0, 3'b000, 2'b00, 32'h40, 1'b1);
    tick();
    check("t3.pc_set", 64'(l_ps), 64'h1);
    check("t3.pc_o", 64'(l_pc), 64'h40);
    drv(4'h0, 4'h0, 4'h0, 3'b000, 2'b00, 32'h0, 1'b0);
    tick();
    drv(4'h9, 4'h0, 4'hf, 3'b000, 2'b11, 32'h1234, 1'b0);
    tick();
    check("t3.rw", 64'(l_rw), 64'h3);
    check("t3.wa", 64'(l_wa), 64'hf);
    check("t3.wah", 64'(l_wah), 64'h0);

    // stall holds a pending redirect; SQUASH=2 suppresses exactly two instructions after release
    drv(T_BRANCH, 4'h0, 4'h0, 3'b000, 2'b00, 32'h800, 1'b0);
    tick();
    check("t4.pc_set", 64'(p_ps), 64'h1);
    check("t4.br", 64'(p_br), 64'h5);
    drv(T_BRANCH, 4'h0, 4'h0, 3'b000, 2'b01, 32'h900, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4.hold_pc_set", 64'(p_ps), 64'h1);
      check("t4.hold_pc_o", 64'(p_pc), 64'h800);
      check("t4.hold_mp", 64'(p_mp), 64'h3);
      check("t4.hold_br", 64'(p_br), 64'h5);
    end
    drv(4'h0, 4'h0, 4'h1, 3'b000, 2'b01, 32'ha1, 1'b0);
    tick();
    check("t4.sq1_rw", 64'(p_rw), 64'h0);
    check("t4.sq1_pc_set", 64'(p_ps), 64'h0);
    drv(4'h0, 4'h0, 4'h1, 3'b000, 2'b01, 32'ha2, 1'b0);
    tick();
    check("t4.sq2_rw", 64'(p_rw), 64'h0);
    drv(4'h0, 4'h0, 4'h1, 3'b000, 2'b01, 32'ha3, 1'b0);
    tick();
    check("t4.live_rw", 64'(p_rw), 64'h1);

    // halt: carrying instruction writes back, then everything frozen; async reset clears
    drv(4'h0, 4'h0, 4'h2, 3'b000, 2'b01, 32'habc, 1'b0);
    halt = 1'b1;
    tick();
    check("t5.rw", 64'(p_rw), 64'h1);
    check("t5.halt", 64'(p_halt), 64'h1);
    check("t5.res", 64'(p_res), 64'habc);
    drv(T_BRANCH, 4'h0, 4'h0, 3'b000, 2'b11, 32'h900, 1'b0);
    tick();
    check("t5.frozen_rw", 64'(p_rw), 64'h0);
    check("t5.frozen_pc_set", 64'(p_ps), 64'h0);
    check("t5.frozen_br", 64'(p_br), 64'h5);
    check("t5.frozen_halt", 64'(p_halt), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t5.arst_halt", 64'(p_halt), 64'h0);
    check("t5.arst_br", 64'(p_br), 64'h0);
    check("t5.arst_mp", 64'(p_mp), 64'h0);
    check("t5.arst_res", 64'(p_res), 64'h0);
    check("t5.arst_pc", 64'(p_pc), 64'h0);
    tick();
    rst = 1'b0;

    // saturation of the branch counter
    drv(T_BRANCH, 4'h0, 4'h0, 3'b000, 2'b00, 32'h10, 1'b1);
    repeat (65534) tick();
    check("t6.br_fffe", 64'(p_br), 64'hfffe);
    repeat (3) tick();
    check("t6.br_sat", 64'(p_br), 64'hffff);
    check("t6.mp", 64'(p_mp), 64'h0);

    // randomized traffic in reset-separated chunks
    for (int c = 0; c < 20; c++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 150; i++) begin
        case ($urandom_range(0, 3))
          0, 1:    ty = T_BRANCH;
          2:       ty = T_JUMP;
          default: ty = 4'($urandom);
        endcase
        ir        = {32'h0, ty, 4'($urandom), 4'($urandom), 20'($urandom)};
        ccr       = 3'($urandom);
        rw        = 2'($urandom);
        result    = $urandom;
        result_hi = $urandom;
        pc        = $urandom;
        pc_fall   = $urandom;
        pred      = (ty == T_BRANCH || ty == T_JUMP) ? 1'($urandom) : 1'b0;
        stall     = ($urandom_range(0, 5) == 0);
        halt      = ($urandom_range(0, 40) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
